// File: rtl/control_sequencer_if.sv
// control_sequencer_if
//   Bundles the sequencer's datapath-facing signals.
//   master : the sequencer (reads ir/con_ff/mem_done/stop, drives run, strobes, alu_op)
//   slave  : the datapath/memory side (drives ir/con_ff/mem_done/stop, reads strobes)
//   Signals:
//     ir[31:0], con_ff, mem_done, stop      status into the sequencer
//     run                                   1 while executing, 0 when halted
//     pc_out..con_in                        datapath strobes
//     read, write                           memory requests
//     gra, grb, grc, r_in, r_out, ba_out    register-select strobes
//     alu_op[ALUW-1:0]                      0=PASS 1=ADD 2=SUB 3=AND 4=OR
interface control_sequencer_if #(
  parameter int ALUW = 4
);
  logic [31:0]     ir;
  logic            con_ff;
  logic            mem_done;
  logic            stop;
  logic            run;
  logic            pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out;
  logic            ir_in, y_in, z_in, zlow_out, c_out, con_in;
  logic            read, write;
  logic            gra, grb, grc, r_in, r_out, ba_out;
  logic [ALUW-1:0] alu_op;

  modport master (
    input  ir, con_ff, mem_done, stop,
    output run, pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out,
    output ir_in, y_in, z_in, zlow_out, c_out, con_in,
    output read, write, gra, grb, grc, r_in, r_out, ba_out, alu_op
  );

  modport slave (
    output ir, con_ff, mem_done, stop,
    input  run, pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out,
    input  ir_in, y_in, z_in, zlow_out, c_out, con_in,
    input  read, write, gra, grb, grc, r_in, r_out, ba_out, alu_op
  );
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer
//   Hard-wired fetch/decode/execute microsequencer for the 32-bit,
//   16-register bus datapath. Walks states T0..T7 (plus HALTED) and decodes
//   one-hot control strobes from the registered state and ir[31:27].
//   Memory transfers stall in T1/T6 until mem_done; HALT or a stop request
//   at an instruction boundary parks the block in HALTED until reset.
//   Ports:
//     clk    system clock, rising edge
//     rst_n  synchronous active-low reset (forces all strobes low while 0)
//     bus    control_sequencer_if.master (status in, strobes out)
module control_sequencer #(
  parameter int OPW  = 5,
  parameter int ALUW = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  control_sequencer_if.master  bus
);

  typedef enum logic [3:0] {T0, T1, T2, T3, T4, T5, T6, T7, HALTED} state_t;
  typedef enum logic [2:0] {C_RR, C_IMM, C_LDI, C_LD, C_ST, C_BR, C_HALT, C_NOP} cls_t;

  localparam logic [OPW-1:0] OP_LD   = OPW'(5'b00000);
  localparam logic [OPW-1:0] OP_LDI  = OPW'(5'b00001);
  localparam logic [OPW-1:0] OP_ST   = OPW'(5'b00010);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00100);
  localparam logic [OPW-1:0] OP_AND  = OPW'(5'b00101);
  localparam logic [OPW-1:0] OP_OR   = OPW'(5'b00110);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(5'b00111);
  localparam logic [OPW-1:0] OP_ANDI = OPW'(5'b01000);
  localparam logic [OPW-1:0] OP_ORI  = OPW'(5'b01001);
  localparam logic [OPW-1:0] OP_BR   = OPW'(5'b10010);
  localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);

  localparam logic [ALUW-1:0] ALU_ADD = ALUW'(1);
  localparam logic [ALUW-1:0] ALU_SUB = ALUW'(2);
  localparam logic [ALUW-1:0] ALU_AND = ALUW'(3);
  localparam logic [ALUW-1:0] ALU_OR  = ALUW'(4);

  state_t          state_reg, state_next, done_next;
  logic            first_reg;   // 1 in the first cycle spent in the current state
  cls_t            cls;
  logic [ALUW-1:0] alu_code;
  logic [OPW-1:0]  opcode;
  logic            ir_unused;

  assign opcode    = bus.ir[31 -: OPW];
  assign ir_unused = ^bus.ir[31-OPW:0];

  // Opcode class and the ALU function its T4 step uses; anything unknown is a nop.
  always_comb begin
    cls      = C_NOP;
    alu_code = '0;
    case (opcode)
      OP_LD:   begin cls = C_LD;   alu_code = ALU_ADD; end
      OP_LDI:  begin cls = C_LDI;  alu_code = ALU_ADD; end
      OP_ST:   begin cls = C_ST;   alu_code = ALU_ADD; end
      OP_ADD:  begin cls = C_RR;   alu_code = ALU_ADD; end
      OP_SUB:  begin cls = C_RR;   alu_code = ALU_SUB; end
      OP_AND:  begin cls = C_RR;   alu_code = ALU_AND; end
      OP_OR:   begin cls = C_RR;   alu_code = ALU_OR;  end
      OP_ADDI: begin cls = C_IMM;  alu_code = ALU_ADD; end
      OP_ANDI: begin cls = C_IMM;  alu_code = ALU_AND; end
      OP_ORI:  begin cls = C_IMM;  alu_code = ALU_OR;  end
      OP_BR:   cls = C_BR;
      OP_HALT: cls = C_HALT;
      default: cls = C_NOP;
    endcase
  end

  // Next state. done_next is the instruction boundary: stop diverts it to HALTED.
  always_comb begin
    done_next  = bus.stop ? HALTED : T0;
    state_next = T0;
    case (state_reg)
      T0: state_next = T1;
      T1: state_next = bus.mem_done ? T2 : T1;
      T2: state_next = T3;
      T3: begin
        case (cls)
          C_NOP:   state_next = done_next;
          C_HALT:  state_next = HALTED;
          default: state_next = T4;
        endcase
      end
      T4: state_next = (cls == C_BR || cls == C_NOP || cls == C_HALT) ? done_next : T5;
      T5: state_next = (cls == C_LD || cls == C_ST) ? T6 : done_next;
      T6: begin
        if (!bus.mem_done) state_next = T6;
        else               state_next = (cls == C_LD) ? T7 : done_next;
      end
      T7:      state_next = done_next;
      HALTED:  state_next = HALTED;
      default: state_next = T0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= T0;
      first_reg <= 1'b1;
    end else begin
      state_reg <= state_next;
      first_reg <= (state_next != state_reg);
    end
  end

  // Strobe decode; everything is held low while reset is asserted.
  always_comb begin
    bus.run      = (state_reg != HALTED);
    bus.pc_out   = 1'b0; bus.pc_in   = 1'b0; bus.inc_pc   = 1'b0;
    bus.mar_in   = 1'b0; bus.mdr_in  = 1'b0; bus.mdr_out  = 1'b0;
    bus.ir_in    = 1'b0; bus.y_in    = 1'b0; bus.z_in     = 1'b0;
    bus.zlow_out = 1'b0; bus.c_out   = 1'b0; bus.con_in   = 1'b0;
    bus.read     = 1'b0; bus.write   = 1'b0;
    bus.gra      = 1'b0; bus.grb     = 1'b0; bus.grc      = 1'b0;
    bus.r_in     = 1'b0; bus.r_out   = 1'b0; bus.ba_out   = 1'b0;
    bus.alu_op   = '0;
    if (rst_n) begin
      case (state_reg)
        T0: begin
          bus.pc_out = 1'b1; bus.mar_in = 1'b1; bus.inc_pc = 1'b1; bus.z_in = 1'b1;
        end
        T1: begin
          // PC update happens once; the read request is held through the stall.
          bus.zlow_out = first_reg;
          bus.pc_in    = first_reg;
          bus.read     = 1'b1;
          bus.mdr_in   = 1'b1;
        end
        T2: begin
          bus.mdr_out = 1'b1; bus.ir_in = 1'b1;
        end
        T3: begin
          case (cls)
            C_RR, C_IMM:      begin bus.grb = 1'b1; bus.r_out  = 1'b1; bus.y_in = 1'b1; end
            C_LDI, C_LD, C_ST: begin bus.grb = 1'b1; bus.ba_out = 1'b1; bus.y_in = 1'b1; end
            C_BR:             begin bus.gra = 1'b1; bus.r_out  = 1'b1; bus.con_in = 1'b1; end
            default: ;
          endcase
        end
        T4: begin
          case (cls)
            C_RR: begin
              bus.grc = 1'b1; bus.r_out = 1'b1; bus.z_in = 1'b1; bus.alu_op = alu_code;
            end
            C_IMM, C_LDI, C_LD, C_ST: begin
              bus.c_out = 1'b1; bus.z_in = 1'b1; bus.alu_op = alu_code;
            end
            C_BR: begin
              bus.grb = 1'b1; bus.r_out = 1'b1; bus.pc_in = bus.con_ff;
            end
            default: ;
          endcase
        end
        T5: begin
          case (cls)
            C_RR, C_IMM, C_LDI: begin bus.zlow_out = 1'b1; bus.gra = 1'b1; bus.r_in = 1'b1; end
            C_LD, C_ST:         begin bus.zlow_out = 1'b1; bus.mar_in = 1'b1; end
            default: ;
          endcase
        end
        T6: begin
          case (cls)
            C_LD: begin bus.read = 1'b1; bus.mdr_in = 1'b1; end
            C_ST: begin
              bus.gra = 1'b1; bus.r_out = 1'b1; bus.mdr_in = 1'b1; bus.write = 1'b1;
            end
            default: ;
          endcase
        end
        T7: begin
          bus.mdr_out = 1'b1; bus.gra = 1'b1; bus.r_in = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  control_sequencer_if #(.ALUW(4)) bus();
  control_sequencer #(.OPW(5), .ALUW(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef logic [24:0] sv_t;
  localparam sv_t RUN      = sv_t'(1) << 24;
  localparam sv_t PC_OUT   = sv_t'(1) << 23;
  localparam sv_t PC_IN    = sv_t'(1) << 22;
  localparam sv_t INC_PC   = sv_t'(1) << 21;
  localparam sv_t MAR_IN   = sv_t'(1) << 20;
  localparam sv_t MDR_IN   = sv_t'(1) << 19;
  localparam sv_t MDR_OUT  = sv_t'(1) << 18;
  localparam sv_t IR_IN    = sv_t'(1) << 17;
  localparam sv_t Y_IN     = sv_t'(1) << 16;
  localparam sv_t Z_IN     = sv_t'(1) << 15;
  localparam sv_t ZLOW_OUT = sv_t'(1) << 14;
  localparam sv_t C_OUT    = sv_t'(1) << 13;
  localparam sv_t CON_IN   = sv_t'(1) << 12;
  localparam sv_t READ     = sv_t'(1) << 11;
  localparam sv_t WRITE    = sv_t'(1) << 10;
  localparam sv_t GRA      = sv_t'(1) << 9;
  localparam sv_t GRB      = sv_t'(1) << 8;
  localparam sv_t GRC      = sv_t'(1) << 7;
  localparam sv_t R_IN     = sv_t'(1) << 6;
  localparam sv_t R_OUT    = sv_t'(1) << 5;
  localparam sv_t BA_OUT   = sv_t'(1) << 4;

  sv_t obs;
  assign obs = {bus.run, bus.pc_out, bus.pc_in, bus.inc_pc, bus.mar_in, bus.mdr_in,
                bus.mdr_out, bus.ir_in, bus.y_in, bus.z_in, bus.zlow_out, bus.c_out,
                bus.con_in, bus.read, bus.write, bus.gra, bus.grb, bus.grc, bus.r_in,
                bus.r_out, bus.ba_out, bus.alu_op};

  int compared   = 0;
  int mismatched = 0;

  // Expected per-cycle trace of one instruction, plus the mem_done to drive.
  sv_t   exp_q[$];
  logic  md_q[$];
  string nm_q[$];

  typedef struct {
    logic [4:0] opc;
    logic       con;
    int         d1;
    int         d6;
    logic       stop_end;
    int         abort_at;
    int         e_run;
    int         e_pcin;
    int         e_read;
    int         e_rin;
    int         e_write;
  } vec_t;

  vec_t tbl[15];

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  function automatic sv_t alu_of(input logic [4:0] opc);
    case (opc)
      5'd0, 5'd1, 5'd2, 5'd3, 5'd7: return sv_t'(1);
      5'd4:                         return sv_t'(2);
      5'd5, 5'd8:                   return sv_t'(3);
      5'd6, 5'd9:                   return sv_t'(4);
      default:                      return sv_t'(0);
    endcase
  endfunction

  function automatic void push(input sv_t v, input logic md, input string nm);
    exp_q.push_back(v);
    md_q.push_back(md);
    nm_q.push_back(nm);
  endfunction

  // Reference: the whole expected strobe trace of one instruction, from T0.
  task automatic build(input logic [4:0] opc, input logic con, input int d1, input int d6);
    exp_q.delete(); md_q.delete(); nm_q.delete();
    push(RUN | PC_OUT | MAR_IN | INC_PC | Z_IN, rb(), "T0");
    for (int i = 0; i <= d1; i++)
      push(RUN | READ | MDR_IN | ((i == 0) ? (ZLOW_OUT | PC_IN) : sv_t'(0)), logic'(i == d1), "T1");
    push(RUN | MDR_OUT | IR_IN, rb(), "T2");
    case (opc)
      5'd3, 5'd4, 5'd5, 5'd6: begin
        push(RUN | GRB | R_OUT | Y_IN, rb(), "T3_rr");
        push(RUN | GRC | R_OUT | Z_IN | alu_of(opc), rb(), "T4_rr");
        push(RUN | ZLOW_OUT | GRA | R_IN, rb(), "T5_rr");
      end
      5'd7, 5'd8, 5'd9: begin
        push(RUN | GRB | R_OUT | Y_IN, rb(), "T3_imm");
        push(RUN | C_OUT | Z_IN | alu_of(opc), rb(), "T4_imm");
        push(RUN | ZLOW_OUT | GRA | R_IN, rb(), "T5_imm");
      end
      5'd1: begin
        push(RUN | GRB | BA_OUT | Y_IN, rb(), "T3_ldi");
        push(RUN | C_OUT | Z_IN | alu_of(opc), rb(), "T4_ldi");
        push(RUN | ZLOW_OUT | GRA | R_IN, rb(), "T5_ldi");
      end
      5'd0, 5'd2: begin
        push(RUN | GRB | BA_OUT | Y_IN, rb(), "T3_mem");
        push(RUN | C_OUT | Z_IN | alu_of(opc), rb(), "T4_mem");
        push(RUN | ZLOW_OUT | MAR_IN, rb(), "T5_mem");
        for (int i = 0; i <= d6; i++) begin
          if (opc == 5'd0) push(RUN | READ | MDR_IN, logic'(i == d6), "T6_ld");
          else             push(RUN | GRA | R_OUT | MDR_IN | WRITE, logic'(i == d6), "T6_st");
        end
        if (opc == 5'd0) push(RUN | MDR_OUT | GRA | R_IN, rb(), "T7_ld");
      end
      5'd18: begin
        push(RUN | GRA | R_OUT | CON_IN, rb(), "T3_br");
        push(RUN | GRB | R_OUT | (con ? PC_IN : sv_t'(0)), rb(), "T4_br");
      end
      default: push(RUN, rb(), "T3_nop_halt");
    endcase
  endtask

  task automatic check(input sv_t got, input sv_t exp, input string nm);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %07h expected %07h", nm, got, exp);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int exp);
    compared++;
    if (got != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic step(input logic [31:0] ir, input logic con, input logic md,
                      input logic st, input sv_t exp, input string nm);
    @(negedge clk);
    rst_n        = 1'b1;
    bus.ir       = ir;
    bus.con_ff   = con;
    bus.mem_done = md;
    bus.stop     = st;
    #1;
    check(obs, exp, nm);
  endtask

  task automatic do_reset(input int n);
    repeat (n) begin
      @(negedge clk);
      rst_n        = 1'b0;
      bus.mem_done = rb();
      bus.stop     = rb();
      #1;
      check(obs & ~RUN, '0, "reset_strobes");
    end
  endtask

  task automatic run_instr(input logic [4:0] opc, input logic con, input int d1, input int d6,
                           input logic stop_end, input int abort_at,
                           output int n_run, output int n_pcin, output int n_read,
                           output int n_rin, output int n_write);
    logic [31:0] ir;
    int          n, lim;
    logic        st;
    build(opc, con, d1, d6);
    ir = {opc, 27'($urandom)};
    n_run = 0; n_pcin = 0; n_read = 0; n_rin = 0; n_write = 0;
    n   = exp_q.size();
    lim = (abort_at >= 0) ? abort_at : n;
    for (int i = 0; i < lim; i++) begin
      st = (i >= n - 2) ? stop_end : rb();
      step(ir, con, md_q[i], st, exp_q[i], nm_q[i]);
      n_run   += int'(bus.run);
      n_pcin  += int'(bus.pc_in);
      n_read  += int'(bus.read);
      n_rin   += int'(bus.r_in);
      n_write += int'(bus.write);
    end
    if (abort_at >= 0) begin
      do_reset(2);
    end else if (opc == 5'd27 || stop_end) begin
      repeat (3) step(ir, con, rb(), rb(), '0, "halted");
      do_reset(1);
    end
  endtask

  initial begin
    int r_run, r_pcin, r_read, r_rin, r_write;
    rst_n = 1'b0; bus.ir = '0; bus.con_ff = 1'b0; bus.mem_done = 1'b0; bus.stop = 1'b0;

    //          opc     con  d1 d6 stop abort  run pcin read rin write
    tbl[0]  = '{5'd3,  1'b0, 0, 0, 1'b0, -1,   6,  1,   1,   1,  0};  // add
    tbl[1]  = '{5'd3,  1'b0, 0, 0, 1'b0,  5,   5,  1,   1,   0,  0};  // add, reset in T4
    tbl[2]  = '{5'd0,  1'b0, 3, 2, 1'b0, -1,  13,  1,   7,   1,  0};  // ld, stalls
    tbl[3]  = '{5'd18, 1'b0, 0, 0, 1'b0, -1,   5,  1,   1,   0,  0};  // br not taken
    tbl[4]  = '{5'd18, 1'b1, 1, 0, 1'b0, -1,   6,  2,   2,   0,  0};  // br taken
    tbl[5]  = '{5'd7,  1'b0, 0, 0, 1'b1, -1,   6,  1,   1,   1,  0};  // addi then stop
    tbl[6]  = '{5'd31, 1'b0, 0, 0, 1'b0, -1,   4,  1,   1,   0,  0};  // undefined
    tbl[7]  = '{5'd2,  1'b0, 1, 0, 1'b0, -1,   8,  1,   2,   0,  1};  // st
    tbl[8]  = '{5'd1,  1'b0, 0, 0, 1'b0, -1,   6,  1,   1,   1,  0};  // ldi
    tbl[9]  = '{5'd27, 1'b0, 2, 0, 1'b0, -1,   6,  1,   3,   0,  0};  // halt
    tbl[10] = '{5'd4,  1'b0, 2, 0, 1'b0, -1,   8,  1,   3,   1,  0};  // sub
    tbl[11] = '{5'd5,  1'b0, 0, 0, 1'b0, -1,   6,  1,   1,   1,  0};  // and
    tbl[12] = '{5'd6,  1'b0, 0, 0, 1'b0, -1,   6,  1,   1,   1,  0};  // or
    tbl[13] = '{5'd8,  1'b0, 0, 0, 1'b0, -1,   6,  1,   1,   1,  0};  // andi
    tbl[14] = '{5'd9,  1'b0, 0, 3, 1'b0, -1,   6,  1,   1,   1,  0};  // ori

    do_reset(2);

    for (int t = 0; t < 15; t++) begin
      run_instr(tbl[t].opc, tbl[t].con, tbl[t].d1, tbl[t].d6, tbl[t].stop_end,
                tbl[t].abort_at, r_run, r_pcin, r_read, r_rin, r_write);
      check_int($sformatf("vec%0d_cycles", t), r_run,   tbl[t].e_run);
      check_int($sformatf("vec%0d_pc_in", t),  r_pcin,  tbl[t].e_pcin);
      check_int($sformatf("vec%0d_read", t),   r_read,  tbl[t].e_read);
      check_int($sformatf("vec%0d_r_in", t),   r_rin,   tbl[t].e_rin);
      check_int($sformatf("vec%0d_write", t),  r_write, tbl[t].e_write);
      $display("vec %0d opc=%05b done (compared=%0d)", t, tbl[t].opc, compared);
    end

    for (int k = 0; k < 80; k++) begin
      logic [4:0] opc;
      logic       se;
      opc = 5'($urandom);
      se  = ($urandom_range(0, 9) == 0);
      run_instr(opc, rb(), $urandom_range(0, 3), $urandom_range(0, 3), se, -1,
                r_run, r_pcin, r_read, r_rin, r_write);
      $display("rand %0d opc=%05b stop=%0b cycles=%0d", k, opc, se, r_run);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
